// File: rtl/reaction_timer.sv
// Reaction timer controller.
//
// A start edge captures a random byte from an external LFSR. The block then
// waits a pseudo-random delay and lights the stimulus lamp. It times the
// player's button press in 1 ms ticks. Pressing during the delay is a false
// start.
//
// Optional feature: define REACTION_BEST_EN to add the best_ms output. It
// holds the best (smallest) valid reaction time seen since reset.
//
// Parameters
//   TICK_DIV    clk cycles per 1 ms tick
//   DELAY_BASE  fixed part of the pre-stimulus delay, ms
//   MAX_MS      reaction count saturation value, ms
//
// Ports
//   clk         system clock, rising edge
//   res         asynchronous active-high reset
//   start       trial request, rising edge sensitive
//   btn         player button (already synchronized), rising edge sensitive
//   rand_in     random byte from the LFSR
//   rand_valid  LFSR capture complete
//   lfsr_en     LFSR free-run enable
//   lfsr_stop   one-cycle LFSR capture pulse
//   go_led      stimulus lamp
//   busy        trial in progress (ARM, WAIT, GO)
//   done        valid result held
//   foul        false start
//   react_ms    last reaction time, ms
//   best_ms     best reaction time, ms (REACTION_BEST_EN only)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no trial since reset, LFSR free-running
// ARM   | capture requested, waiting for rand_valid
// WAIT  | counting down the random delay, lamp off
// GO    | lamp on, counting reaction time
// DONE  | result in react_ms, LFSR free-running
// FOUL  | button pressed before the lamp, LFSR free-running
module reaction_timer #(
   parameter int TICK_DIV   = 50000,
   parameter int DELAY_BASE = 1000,
   parameter int MAX_MS     = 9999
) (
   input  logic        clk,
   input  logic        res,
   input  logic        start,
   input  logic        btn,
   input  logic [7:0]  rand_in,
   input  logic        rand_valid,
   output logic        lfsr_en,
   output logic        lfsr_stop,
   output logic        go_led,
   output logic        busy,
   output logic        done,
   output logic        foul,
   output logic [13:0] react_ms
`ifdef REACTION_BEST_EN
   ,
   output logic [13:0] best_ms
`endif
);

   localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [13:0]   MAX_VAL    = 14'(MAX_MS);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARM  = 3'd1,
      WAIT = 3'd2,
      GO   = 3'd3,
      DONE = 3'd4,
      FOUL = 3'd5
   } state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [11:0]   delay_ms;
   logic          start_q;
   logic          btn_q;
   logic          start_rise;
   logic          btn_rise;
   logic          tick;
   logic [11:0]   delay_load;

   assign start_rise = start & ~start_q;
   assign btn_rise   = btn & ~btn_q;
   assign tick       = (presc == PRESC_LAST);
   // 8 * rand_in is a 3-bit left shift of the random byte
   assign delay_load = 12'(DELAY_BASE) + {1'b0, rand_in, 3'b000};

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state     <= IDLE;
         lfsr_en   <= 1'b1;
         lfsr_stop <= 1'b0;
         go_led    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         foul      <= 1'b0;
         react_ms  <= '0;
         presc     <= '0;
         delay_ms  <= '0;
         start_q   <= 1'b0;
         btn_q     <= 1'b0;
`ifdef REACTION_BEST_EN
         best_ms   <= '1;
`endif
      end else begin
         start_q   <= start;
         btn_q     <= btn;
         lfsr_stop <= 1'b0;
         // free-running prescaler; every state change below overrides this
         // with a clear so the first tick lands TICK_DIV cycles after entry
         presc     <= tick ? '0 : presc + PW'(1);

         case (state)
            IDLE, DONE, FOUL: begin
               if (start_rise) begin
                  state     <= ARM;
                  lfsr_stop <= 1'b1;
                  lfsr_en   <= 1'b0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  foul      <= 1'b0;
                  presc     <= '0;
               end
            end

            ARM: begin
               if (rand_valid) begin
                  state    <= WAIT;
                  delay_ms <= delay_load;
                  presc    <= '0;
               end
            end

            WAIT: begin
               // a press on the terminal tick still counts as a false start
               if (btn_rise) begin
                  state   <= FOUL;
                  foul    <= 1'b1;
                  go_led  <= 1'b0;
                  busy    <= 1'b0;
                  lfsr_en <= 1'b1;
                  presc   <= '0;
               end else if (tick) begin
                  if (delay_ms <= 12'd1) begin
                     state    <= GO;
                     delay_ms <= '0;
                     go_led   <= 1'b1;
                     react_ms <= '0;
                     presc    <= '0;
                  end else begin
                     delay_ms <= delay_ms - 12'd1;
                  end
               end
            end

            GO: begin
               // the press wins over a coincident tick, so react_ms freezes
               if (btn_rise) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  go_led  <= 1'b0;
                  busy    <= 1'b0;
                  lfsr_en <= 1'b1;
                  presc   <= '0;
`ifdef REACTION_BEST_EN
                  if (react_ms < best_ms) best_ms <= react_ms;
`endif
               end else if (tick) begin
                  if (react_ms >= MAX_VAL - 14'd1) begin
                     state    <= DONE;
                     react_ms <= MAX_VAL;
                     done     <= 1'b1;
                     go_led   <= 1'b0;
                     busy     <= 1'b0;
                     lfsr_en  <= 1'b1;
                     presc    <= '0;
`ifdef REACTION_BEST_EN
                     if (MAX_VAL < best_ms) best_ms <= MAX_VAL;
`endif
                  end else begin
                     react_ms <= react_ms + 14'd1;
                  end
               end
            end

            default: begin
               state   <= IDLE;
               lfsr_en <= 1'b1;
               busy    <= 1'b0;
               go_led  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter TICK_DIV, default 50000, clk cycles per 1 ms tick.
REQ-002 Parameter DELAY_BASE, default 1000, fixed part of the random pre-stimulus delay, in ms.
REQ-003 Parameter MAX_MS, default 9999, saturation value of the reaction count, in ms.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 res  input  1  asynchronous active-high reset.
REQ-006 start  input  1  synchronous level; a rising edge requests a new trial.
REQ-007 btn  input  1  player button, already synchronized to clk; a rising edge is a press.
REQ-008 rand_in  input  8  random byte from the LFSR output.
REQ-009 rand_valid  input  1  LFSR capture-complete flag (cenable).
REQ-010 lfsr_en  output  1  free-run enable to the LFSR.
REQ-011 lfsr_stop  output  1  one-cycle capture pulse to the LFSR.
REQ-012 go_led  output  1  stimulus lamp.
REQ-013 busy  output  1  trial in progress (ARM, WAIT or GO).
REQ-014 done  output  1  valid result held.
REQ-015 foul  output  1  false start.
REQ-016 react_ms  output  14  last reaction time, in ms.

Function
REQ-017 The FSM SHALL have the states IDLE, ARM, WAIT, GO, DONE and FOUL.
REQ-018 lfsr_en SHALL be 1 in IDLE, DONE and FOUL, and 0 otherwise.
REQ-019 In IDLE, DONE or FOUL, a start rising edge SHALL pulse lfsr_stop for exactly one cycle and move the FSM to ARM on the next edge.
REQ-020 In ARM, the FSM SHALL wait for rand_valid=1, then load delay_ms = DELAY_BASE + 8*rand_in (12-bit, range 1000..3040 at defaults) and enter WAIT.
REQ-021 The ms prescaler SHALL clear on every state entry and emit one tick every TICK_DIV cycles thereafter.
REQ-022 In WAIT, each tick SHALL decrement delay_ms; when the count reaches 0 the FSM SHALL enter GO, set go_led=1 and clear react_ms to 0.
REQ-023 A btn rising edge in WAIT SHALL enter FOUL (foul=1, go_led=0); a btn edge in the same cycle as the terminal tick SHALL also be FOUL.
REQ-024 In GO, each tick SHALL increment react_ms, saturating at MAX_MS.
REQ-025 A btn rising edge in GO SHALL enter DONE with react_ms frozen, go_led=0 and done=1.
REQ-026 If react_ms reaches MAX_MS in GO, the FSM SHALL enter DONE with react_ms=MAX_MS.
REQ-027 start edges SHALL be ignored in ARM, WAIT and GO.
REQ-028 A btn edge in IDLE, ARM, DONE or FOUL SHALL have no effect.
REQ-029 A held btn SHALL count only once; edge detection SHALL be against the previous-cycle value.
REQ-030 done and foul SHALL clear on the entry to ARM.

Reset
REQ-031 res=1 SHALL force, immediately and asynchronously: state IDLE, lfsr_en=1, lfsr_stop=0, go_led=0, busy=0, done=0, foul=0, react_ms=0, prescaler=0, delay_ms=0, btn/start edge history=0.
REQ-032 res asserted mid-trial SHALL abandon the trial with no result; the next trial SHALL require a fresh start edge after release.

Configuration
REQ-033 With REACTION_BEST_EN defined, the block SHALL add the output best_ms[13:0], reset to all ones (16383), updated to react_ms on each DONE entry where react_ms < best_ms, and unchanged on FOUL.
REQ-034 Without REACTION_BEST_EN, the best_ms port and its register SHALL NOT exist.

Verification (bench TICK_DIV=4, DELAY_BASE=10, MAX_MS=50)
REQ-035 Start edge, rand_valid with rand_in=2 -> one-cycle lfsr_stop; WAIT lasts 26 ticks (104 cycles); go_led rises.
REQ-036 btn edge 7 ticks after go_led -> done=1, react_ms=7, go_led=0, busy=0.
REQ-037 btn edge during WAIT, and separately on the terminal tick -> foul=1, done=0, go_led never asserted.
REQ-038 No btn in GO -> DONE after 50 ticks with react_ms=50; a further start edge re-arms with done=0.
REQ-039 res pulse mid-GO -> all outputs at reset values in the same cycle; a start edge while busy is ignored.
REQ-040 With REACTION_BEST_EN, trials of 9, 5, foul, 7 -> best_ms reads 9, 5, 5, 5.
